// File: rtl/sram_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_bus_arbiter_if
// Groups the three SRAM-like handshake channels that meet at the arbiter:
//   inst_* : instruction fetch (read-only requester)
//   data_* : memory stage (load/store requester)
//   mem_*  : the shared port toward the external bus bridge
// Modports:
//   master : the arbiter's view (accepts inst/data requests, drives mem_*)
//   slave  : the surrounding environment (requesters plus bus bridge)
// ----------------------------------------------------------------------------
interface sram_bus_arbiter_if;
    // Fetch channel
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    // Memory-stage channel
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // Shared bus channel
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wen, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wen, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sram_bus_arbiter
// Shares one SRAM-like memory port between instruction fetch and the data
// memory stage. One transaction is outstanding at a time. The data side has
// fixed priority; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while fetch is waiting.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : sram_bus_arbiter_if.master (inst_*, data_*, mem_* channels)
//
// Parameters:
//   STARVE_LIMIT : data grants allowed while inst_req pends (1..15)
//
// Optional build macro:
//   ARB_KSEG_MAP_EN : when defined, addresses in 0x8000_0000..0xBFFF_FFFF
//                     are folded to physical {3'b000, addr[28:0]} at grant.
// ----------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_bus_arbiter_if.master bus
);

    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
    localparam logic [3:0] STARVE_MAX_C   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t      state_r;
    state_t      state_s;
    owner_t      owner_r;
    logic        wr_r;
    logic [3:0]  wen_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  starve_cnt_r;

    logic        grant_data_s;
    logic        grant_inst_s;
    logic [31:0] grant_addr_s;

`ifdef ARB_KSEG_MAP_EN
    // kseg0/kseg1 (top nibble 0x8..0xB) fold onto the low 512 MB.
    function automatic logic [31:0] kseg_map(input logic [31:0] addr);
        logic [31:0] mapped;
        if (addr[31:30] == 2'b10) begin
            mapped = {3'b000, addr[28:0]};
        end else begin
            mapped = addr;
        end
        return mapped;
    endfunction
`endif

    // Arbitration decision and the address to latch on a grant (IDLE only).
    always_comb begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        grant_addr_s = 32'h0000_0000;
        if (state_r == ST_IDLE) begin
            if (bus.data_req && (!bus.inst_req || (starve_cnt_r < STARVE_LIMIT_C))) begin
                grant_data_s = 1'b1;
                grant_addr_s = bus.data_addr;
            end else if (bus.inst_req) begin
                grant_inst_s = 1'b1;
                grant_addr_s = bus.inst_addr;
            end else begin
                grant_addr_s = 32'h0000_0000;
            end
        end else begin
            grant_addr_s = 32'h0000_0000;
        end
`ifdef ARB_KSEG_MAP_EN
        grant_addr_s = kseg_map(grant_addr_s);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant latch: owner, request fields and the starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= OWN_INST;
            wr_r         <= 1'b0;
            wen_r        <= 4'b0000;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            starve_cnt_r <= 4'd0;
        end else if (grant_data_s) begin
            owner_r <= OWN_DATA;
            wr_r    <= bus.data_wr;
            wen_r   <= bus.data_wen;
            addr_r  <= grant_addr_s;
            wdata_r <= bus.data_wdata;
            // Only count data grants that actually made fetch wait.
            if (bus.inst_req) begin
                starve_cnt_r <= (starve_cnt_r == STARVE_MAX_C) ? STARVE_MAX_C
                                                               : starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= 4'd0;
            end
        end else if (grant_inst_s) begin
            owner_r      <= OWN_INST;
            wr_r         <= 1'b0;
            wen_r        <= 4'b0000;
            addr_r       <= grant_addr_s;
            wdata_r      <= 32'h0000_0000;
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Next-state logic and handshake outputs; ok pulses route only to the owner.
    always_comb begin
        state_s          = state_r;
        bus.mem_req      = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A stale mem_data_ok here is deliberately dropped.
                if (grant_data_s || grant_inst_s) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                bus.mem_req = 1'b1;
                if (bus.mem_addr_ok) begin
                    state_s = ST_DATA;
                    if (owner_r == OWN_DATA) begin
                        bus.data_addr_ok = 1'b1;
                    end else begin
                        bus.inst_addr_ok = 1'b1;
                    end
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.mem_data_ok) begin
                    state_s = ST_IDLE;
                    if (owner_r == OWN_DATA) begin
                        bus.data_data_ok = 1'b1;
                    end else begin
                        bus.inst_data_ok = 1'b1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_wr     = wr_r;
    assign bus.mem_wen    = wen_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = wdata_r;
    assign bus.inst_rdata = bus.mem_rdata;
    assign bus.data_rdata = bus.mem_rdata;

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between instruction fetch (read-only) and the data-memory stage (load/store).
- Sits between the fetch unit / memory stage and the external bus bridge.
- Allows one outstanding transaction at a time.
- Data side has fixed priority, with a starvation limiter that protects fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before fetch is forced a grant; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted by the bus (1-cycle pulse)
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  32  fetch read data
- data_req  in  1  memory-stage request
- data_wr  in  1  1 = store, 0 = load
- data_wen  in  4  byte write enables, already lane-shifted
- data_addr  in  32  data address
- data_wdata  in  32  store data, already lane-replicated
- data_addr_ok  out  1  data request accepted by the bus (1-cycle pulse)
- data_data_ok  out  1  load data valid or store complete (1-cycle pulse)
- data_rdata  out  32  load read data
- mem_req  out  1  bus request
- mem_wr  out  1  bus write
- mem_wen  out  4  bus byte enables
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_addr_ok  in  1  bus accepted address
- mem_data_ok  in  1  bus data/response valid
- mem_rdata  in  32  bus read data

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- States: IDLE, ADDR, DATA. An owner register (INST/DATA) records the granted requester.
- IDLE:
  - If data_req and (!inst_req or starve_cnt < STARVE_LIMIT): grant DATA.
  - Else if inst_req: grant INST.
  - On a grant, latch owner, wr, wen, addr and wdata. For INST: wr=0, wen=0, wdata=0. Go to ADDR.
- ADDR:
  - mem_req=1; mem_* driven from the latched registers.
  - On mem_addr_ok, pulse the owner's *_addr_ok in the same cycle (combinational) and go to DATA.
  - mem_data_ok in ADDR is ignored.
- DATA:
  - mem_req=0.
  - On mem_data_ok, pulse the owner's *_data_ok in the same cycle and return to IDLE.
  - Both *_rdata = mem_rdata combinationally; valid only with the matching data_ok.
- Latency:
  - Grant in IDLE at cycle N; mem_req high from cycle N+1.
  - Minimum 3 cycles from request to data_ok.
  - One IDLE bubble between back-to-back transactions.
- Requester rule: each requester holds req and fields until its addr_ok. The arbiter samples fields only in IDLE, so later changes are harmless.
- starve_cnt (4 bits):
  - Incremented on a DATA grant while inst_req=1.
  - Cleared on any INST grant, or on a DATA grant with inst_req=0.
  - Saturates at 15.
- Simultaneous requests in IDLE: data wins unless starve_cnt has reached STARVE_LIMIT.
- Reset values:
  - state=IDLE; owner=INST; starve_cnt=0; latched registers = 0.
  - mem_req, all *_addr_ok and all *_data_ok = 0.
- Reset mid-transaction: the transaction is abandoned. A stale mem_data_ok arriving in IDLE produces no *_data_ok pulse.
- mem_addr_ok and mem_data_ok never pulse the non-owner side.

Optional Feature:
- Macro: ARB_KSEG_MAP_EN.
- Defined: the latched address is translated at grant time. If addr[31:28] is in 0x8..0xB, mem_addr = {3'b000, addr[28:0]}; otherwise it passes through.
- Undefined: mem_addr equals the latched address unchanged.

Test Plan:
- Single load: data_req=1, wr=0, addr=0x0000_0010; mem_addr_ok at cycle 2, mem_data_ok at cycle 4 with rdata=0xDEADBEEF -> data_addr_ok pulses cycle 2; data_data_ok and data_rdata=0xDEADBEEF at cycle 4; inst_* outputs stay 0.
- Conflict: inst_req and data_req both held, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...; starve_cnt returns to 0 after the inst grant.
- Store: data_wr=1, wen=4'b1100, wdata=0x12341234 -> mem_wr=1, mem_wen=4'b1100, mem_wdata=0x12341234 held through ADDR until mem_addr_ok.
- Reset in DATA state: rst for 1 cycle, then stale mem_data_ok=1 -> no *_data_ok pulse; state IDLE; mem_req=0.
- ARB_KSEG_MAP_EN defined: inst_addr=0xBFC0_0000 -> mem_addr=0x1FC0_0000. inst_addr=0x0040_0000 -> mem_addr unchanged. Undefined: 0xBFC0_0000 passes through unchanged.
- Bus stall: mem_addr_ok held low 10 cycles -> mem_req and mem_addr stay stable all 10 cycles; no addr_ok pulse until acceptance.
